pfe_dispatch: RTL and testbench
===============================

# pfe_dispatch

Parametrised prefetch dispatch engine: the next generation of the prefetch-engine front end. It accepts one prefetch op per cycle from the prefetch generator and expands it into up to two line-address candidates (laddr+d, laddr+d2), each gated by its weight. Candidates are steered to NPIPE data-cache request channels by low line-address bits, through per-channel FIFOs with valid/retry handshakes. Per-pipe stat counters are merged into one saturating aggregate.

## Interface
- NPIPE, 2, number of DC request channels; power of two, 1..8
- LADDR_W, 39, line-address width
- SPTBR_W, 38, page-table base width
- DELTA_W, 8, signed delta width, in cache lines
- WGT_W, 3, unsigned weight width
- WTHRESH, 2, minimum weight for a candidate to issue
- WL1, 5, minimum weight for an L1 fill; below this, l2=1
- FDEPTH, 4, per-channel FIFO depth; power of two, >=2
- STATBITS, 16, width of each stat counter
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- op_valid  in  1  prefetch op offered
- op_retry  out  1  op not accepted this cycle
- op_d, op_d2  in  DELTA_W each  signed line deltas
- op_w, op_w2  in  WGT_W each  weights for d / d2
- op_laddr  in  LADDR_W  trigger line address
- op_sptbr  in  SPTBR_W  address-space tag, carried with each request
- req_valid  out  NPIPE  per-channel request valid
- req_retry  in  NPIPE  per-channel back-pressure
- req_laddr  out  NPIPE*LADDR_W  channel i at [i*LADDR_W +: LADDR_W]
- req_sptbr  out  NPIPE*SPTBR_W  per-channel sptbr
- req_l2  out  NPIPE  1 = fill to L2 only
- stats_in  in  NPIPE*8*STATBITS  per-pipe stat vectors, 8 counters each
- stats_out  out  8*STATBITS  element-wise aggregate
- ndrop  out  STATBITS  count of candidates suppressed by weight, zero-delta or duplicate

## Operation
- Accept: op_valid && !op_retry.
- op_retry = 1 when any channel FIFO has fewer than 2 free entries. It is computed from registered occupancy only and has no combinational path from op_*.
- Candidate A: laddr + sext(d). It is enabled when w >= WTHRESH and d != 0. l2 = (w < WL1).
- Candidate B: laddr + sext(d2), with the same rules using w2 and d2.
- Address add is modulo 2^LADDR_W; wrap-around is legal and is not dropped.
- Duplicate rule: if both candidates are enabled and their addresses are equal, issue only A, with l2 = l2A & l2B.
- Channel = candidate laddr[log2(NPIPE)-1:0]. When NPIPE=1, everything goes to channel 0.
- Both candidates can target the same channel. In that case both are written in the same cycle, A before B.
- sptbr is copied to every issued candidate.
- On accept, ndrop += the number of suppressed candidates (0..2). The counter saturates at all-ones.
- Channel output: req_valid[i] = FIFO i not empty; the payload is the FIFO head.
- Channel pop: req_valid[i] && !req_retry[i].
- Channels are independent. A stall on one channel does not block the others until it reaches the op_retry threshold.
- The payload is held stable while a channel is valid and retried.
- Stats: stats_out[k] = saturating sum over pipes of stats_in counter k.
  - The sum is computed at STATBITS+log2(NPIPE) bits, clamped to all-ones, then registered.
- Reset (reset==0 at an edge):
  - all FIFOs empty; req_valid = 0
  - op_retry = 0 from the next cycle
  - stats_out = 0, ndrop = 0
  - an in-flight op in the reset cycle is discarded

## Timing
- Op accepted at edge N: its requests are visible on req_* after edge N (cycle N+1).
- Latency is 1 cycle; there is no combinational op->req path.
- Simultaneous pop and push on the same FIFO in one cycle is legal. Occupancy is unchanged for one push, or +1 for two pushes.
- A full FIFO never overflows. The <2-free rule guarantees space for a double push.
- The FIFO pointers wrap modulo FDEPTH.
- Stats latency: stats_in at edge N appears on stats_out after edge N.
- op_retry updates one cycle after the occupancy change that causes it.

## Test plan
- Weight gating:
  - stimulus: NPIPE=2, laddr=0x100, d=1, w=6, d2=2, w2=1
  - response: channel 1 gets 0x101 with l2=0 at N+1; channel 0 stays idle; ndrop=1
- Same-channel and duplicate handling:
  - stimulus A: laddr=0x100, d=2, d2=4, w=w2=3
  - response A: channel 0 emits 0x102 then 0x104, both l2=1
  - stimulus B: d=d2=3, w=5, w2=2
  - response B: a single request 0x103 with l2=0; ndrop=1
- Wrap and zero delta:
  - stimulus: laddr=all-ones, d=1, d2=0, both weights 7
  - response: request 0x0 on channel 0; d2 dropped; ndrop=1
- Back-pressure:
  - stimulus: hold req_retry[0]=1 with FDEPTH=4; stream ops to channel 0
  - response: op_retry rises once occupancy reaches 3; no entry is lost or reordered after retry drops
  - check: channel 1 traffic continues meanwhile
- Stats saturation:
  - stimulus: NPIPE=4, STATBITS=16, counter 0 = 0x8000 on every pipe
  - response: stats_out counter 0 = 0xFFFF; other counters sum exactly
- Reset mid-operation:
  - stimulus: assert reset=0 with FIFOs partly full
  - response: after the edge, req_valid=0, ndrop=0, stats_out=0; op_retry=0 in the next cycle

Source files
------------

// File: rtl/pfe_dispatch.sv
// pfe_dispatch: expands prefetch ops into weighted line candidates steered to per-channel request FIFOs
module pfe_dispatch #(
  parameter int NPIPE    = 2,
  parameter int LADDR_W  = 39,
  parameter int SPTBR_W  = 38,
  parameter int DELTA_W  = 8,
  parameter int WGT_W    = 3,
  parameter int WTHRESH  = 2,
  parameter int WL1      = 5,
  parameter int FDEPTH   = 4,
  parameter int STATBITS = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          op_valid,
  output logic                          op_retry,
  input  logic [DELTA_W-1:0]            op_d,
  input  logic [DELTA_W-1:0]            op_d2,
  input  logic [WGT_W-1:0]              op_w,
  input  logic [WGT_W-1:0]              op_w2,
  input  logic [LADDR_W-1:0]            op_laddr,
  input  logic [SPTBR_W-1:0]            op_sptbr,
  output logic [NPIPE-1:0]              req_valid,
  input  logic [NPIPE-1:0]              req_retry,
  output logic [NPIPE*LADDR_W-1:0]      req_laddr,
  output logic [NPIPE*SPTBR_W-1:0]      req_sptbr,
  output logic [NPIPE-1:0]              req_l2,
  input  logic [NPIPE*8*STATBITS-1:0]   stats_in,
  output logic [8*STATBITS-1:0]         stats_out,
  output logic [STATBITS-1:0]           ndrop
);
  localparam int PW = NPIPE > 1 ? $clog2(NPIPE) : 1;
  localparam int AW = $clog2(FDEPTH);
  localparam int SW = STATBITS + PW;
  localparam logic [AW:0] CNT_HI = (AW+1)'(FDEPTH - 2);
  typedef struct packed {
    logic [LADDR_W-1:0] laddr;
    logic [SPTBR_W-1:0] sptbr;
    logic               l2;
  } ent_t;
  ent_t                 mem_q [NPIPE][FDEPTH];
  logic [AW-1:0]        wr_q [NPIPE];
  logic [AW-1:0]        rd_q [NPIPE];
  logic [AW:0]          cnt_q [NPIPE];
  logic [AW:0]          cnt_d [NPIPE];
  logic [NPIPE-1:0]     push_a, push_b, pop;
  logic [LADDR_W-1:0]   addr_a, addr_b;
  logic                 en_a, en_b, dup, acc, l2_a, l2_b, l2_m;
  logic [PW-1:0]        ch_a, ch_b;
  logic [1:0]           drop;
  logic [STATBITS:0]    ndrop_sum;
  logic [STATBITS-1:0]  ndrop_q, ndrop_d;
  logic [SW-1:0]        sum [8];
  logic [8*STATBITS-1:0] stats_q, stats_d;
  always_comb begin
    op_retry = 1'b0;
    for (int i = 0; i < NPIPE; i++) op_retry = op_retry | (cnt_q[i] > CNT_HI);
    addr_a = op_laddr + {{(LADDR_W-DELTA_W){op_d[DELTA_W-1]}}, op_d};
    addr_b = op_laddr + {{(LADDR_W-DELTA_W){op_d2[DELTA_W-1]}}, op_d2};
    en_a = op_w >= WGT_W'(WTHRESH) && op_d != '0;
    en_b = op_w2 >= WGT_W'(WTHRESH) && op_d2 != '0;
    l2_a = op_w < WGT_W'(WL1);
    l2_b = op_w2 < WGT_W'(WL1);
    dup = en_a && en_b && addr_a == addr_b;
    l2_m = l2_a && (!dup || l2_b);
    acc = op_valid && !op_retry;
    ch_a = NPIPE == 1 ? '0 : addr_a[PW-1:0];
    ch_b = NPIPE == 1 ? '0 : addr_b[PW-1:0];
    drop = acc ? 2'(!en_a) + 2'(!en_b) + 2'(dup) : 2'd0;
    ndrop_sum = {1'b0, ndrop_q} + (STATBITS+1)'(drop);
    ndrop_d = ndrop_sum[STATBITS] ? '1 : ndrop_sum[STATBITS-1:0];
    for (int i = 0; i < NPIPE; i++) begin
      push_a[i] = acc && en_a && ch_a == PW'(i);
      push_b[i] = acc && en_b && !dup && ch_b == PW'(i);
      pop[i] = cnt_q[i] != '0 && !req_retry[i];
      cnt_d[i] = cnt_q[i] + (AW+1)'(push_a[i]) + (AW+1)'(push_b[i]) - (AW+1)'(pop[i]);
      req_valid[i] = cnt_q[i] != '0;
      req_laddr[i*LADDR_W +: LADDR_W] = mem_q[i][rd_q[i]].laddr;
      req_sptbr[i*SPTBR_W +: SPTBR_W] = mem_q[i][rd_q[i]].sptbr;
      req_l2[i] = mem_q[i][rd_q[i]].l2;
    end
    for (int k = 0; k < 8; k++) begin
      sum[k] = '0;
      for (int p = 0; p < NPIPE; p++) sum[k] = sum[k] + SW'(stats_in[(p*8+k)*STATBITS +: STATBITS]);
      stats_d[k*STATBITS +: STATBITS] = sum[k][SW-1:STATBITS] != '0 ? '1 : sum[k][STATBITS-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NPIPE; i++) begin
        wr_q[i] <= '0;
        rd_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      ndrop_q <= '0;
      stats_q <= '0;
    end else begin
      for (int i = 0; i < NPIPE; i++) begin
        wr_q[i] <= wr_q[i] + AW'(push_a[i]) + AW'(push_b[i]);
        rd_q[i] <= rd_q[i] + AW'(pop[i]);
        cnt_q[i] <= cnt_d[i];
      end
      ndrop_q <= ndrop_d;
      stats_q <= stats_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPIPE; i++) begin
      if (push_a[i]) mem_q[i][wr_q[i]] <= {addr_a, op_sptbr, l2_m};
      if (push_b[i]) mem_q[i][wr_q[i] + AW'(push_a[i])] <= {addr_b, op_sptbr, l2_b};
    end
  end
  assign ndrop = ndrop_q;
  assign stats_out = stats_q;
endmodule

// File: tb/tb_pfe_dispatch.sv
// tb_pfe_dispatch: directed and randomized checks of pfe_dispatch against a queue-based model
module tb_pfe_dispatch;
  localparam int NPIPE = 2, LADDR_W = 39, SPTBR_W = 38, DELTA_W = 8, WGT_W = 3;
  localparam int WTHRESH = 2, WL1 = 5, FDEPTH = 4, STATBITS = 16;
  localparam longint MASK = (64'd1 << LADDR_W) - 1;
  typedef struct packed {
    logic [LADDR_W-1:0] laddr;
    logic [SPTBR_W-1:0] sptbr;
    logic               l2;
  } ent_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic op_valid = 1'b0, op_retry;
  logic [DELTA_W-1:0] op_d = '0, op_d2 = '0;
  logic [WGT_W-1:0] op_w = '0, op_w2 = '0;
  logic [LADDR_W-1:0] op_laddr = '0;
  logic [SPTBR_W-1:0] op_sptbr = '0;
  logic [NPIPE-1:0] req_valid, req_retry = '0, req_l2;
  logic [NPIPE*LADDR_W-1:0] req_laddr;
  logic [NPIPE*SPTBR_W-1:0] req_sptbr;
  logic [NPIPE*8*STATBITS-1:0] stats_in = '0;
  logic [8*STATBITS-1:0] stats_out;
  logic [STATBITS-1:0] ndrop;
  int n_cmp = 0, n_fail = 0;
  ent_t q [NPIPE][$];
  longint m_ndrop;
  logic [8*STATBITS-1:0] m_stats;
  bit chk_on = 0;

  pfe_dispatch #(.NPIPE(NPIPE), .LADDR_W(LADDR_W), .SPTBR_W(SPTBR_W), .DELTA_W(DELTA_W),
    .WGT_W(WGT_W), .WTHRESH(WTHRESH), .WL1(WL1), .FDEPTH(FDEPTH), .STATBITS(STATBITS)) dut (
    .clk(clk), .reset(rst_n), .op_valid(op_valid), .op_retry(op_retry), .op_d(op_d), .op_d2(op_d2),
    .op_w(op_w), .op_w2(op_w2), .op_laddr(op_laddr), .op_sptbr(op_sptbr), .req_valid(req_valid),
    .req_retry(req_retry), .req_laddr(req_laddr), .req_sptbr(req_sptbr), .req_l2(req_l2),
    .stats_in(stats_in), .stats_out(stats_out), .ndrop(ndrop));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [LADDR_W-1:0] la, input int d, input int w, input int d2, input int w2);
    op_valid = 1'b1;
    op_laddr = la;
    op_d = DELTA_W'(d);
    op_w = WGT_W'(w);
    op_d2 = DELTA_W'(d2);
    op_w2 = WGT_W'(w2);
    op_sptbr = SPTBR_W'({$urandom, $urandom});
  endtask

  function automatic logic [LADDR_W:0] ch_laddr(input int i);
    return {1'b0, req_laddr[i*LADDR_W +: LADDR_W]};
  endfunction

  // Reference model: compare the state reached so far, then apply this cycle's inputs.
  always @(negedge clk) begin
    bit exp_retry;
    exp_retry = 0;
    for (int i = 0; i < NPIPE; i++) if (q[i].size() >= FDEPTH - 1) exp_retry = 1;
    if (chk_on) begin
      for (int i = 0; i < NPIPE; i++) begin
        check($sformatf("model req_valid[%0d]", i), req_valid[i], q[i].size() > 0);
        if (q[i].size() > 0) begin
          check($sformatf("model req_laddr[%0d]", i), req_laddr[i*LADDR_W +: LADDR_W], q[i][0].laddr);
          check($sformatf("model req_sptbr[%0d]", i), req_sptbr[i*SPTBR_W +: SPTBR_W], q[i][0].sptbr);
          check($sformatf("model req_l2[%0d]", i), req_l2[i], q[i][0].l2);
        end
      end
      check("model op_retry", op_retry, exp_retry);
      check("model ndrop", ndrop, m_ndrop[STATBITS-1:0]);
      check("model stats_out", stats_out, m_stats);
    end
    if (!rst_n) begin
      for (int i = 0; i < NPIPE; i++) q[i].delete();
      m_ndrop = 0;
      m_stats = '0;
      chk_on = 1;
    end else if (chk_on) begin
      for (int i = 0; i < NPIPE; i++) if (q[i].size() > 0 && !req_retry[i]) void'(q[i].pop_front());
      if (op_valid && !exp_retry) begin
        longint la, lb;
        bit ea, eb;
        int issued;
        ent_t e;
        la = (longint'(op_laddr) + longint'($signed(op_d))) & MASK;
        lb = (longint'(op_laddr) + longint'($signed(op_d2))) & MASK;
        ea = int'(op_w) >= WTHRESH && op_d != 0;
        eb = int'(op_w2) >= WTHRESH && op_d2 != 0;
        issued = 0;
        e.sptbr = op_sptbr;
        if (ea) begin
          e.laddr = la[LADDR_W-1:0];
          e.l2 = int'(op_w) < WL1;
          if (eb && la == lb) e.l2 = e.l2 && int'(op_w2) < WL1;
          q[int'(la % NPIPE)].push_back(e);
          issued++;
        end
        if (eb && !(ea && la == lb)) begin
          e.laddr = lb[LADDR_W-1:0];
          e.l2 = int'(op_w2) < WL1;
          q[int'(lb % NPIPE)].push_back(e);
          issued++;
        end
        m_ndrop = m_ndrop + 2 - issued;
        if (m_ndrop > (1 << STATBITS) - 1) m_ndrop = (1 << STATBITS) - 1;
      end
      for (int k = 0; k < 8; k++) begin
        longint s;
        s = 0;
        for (int p = 0; p < NPIPE; p++) s += longint'(stats_in[(p*8+k)*STATBITS +: STATBITS]);
        if (s > (1 << STATBITS) - 1) s = (1 << STATBITS) - 1;
        m_stats[k*STATBITS +: STATBITS] = s[STATBITS-1:0];
      end
    end
  end

  initial begin
    step();
    step();
    rst_n = 1'b1;
    check("reset req_valid", req_valid, 0);
    check("reset ndrop", ndrop, 0);
    // weight gating
    set_op(39'h100, 1, 6, 2, 1);
    step();
    op_valid = 1'b0;
    check("gate req_valid", req_valid, 2'b10);
    check("gate laddr1", ch_laddr(1), 40'h101);
    check("gate l2", req_l2[1], 0);
    check("gate ndrop", ndrop, 1);
    step();
    // same channel, two entries in order
    set_op(39'h100, 2, 3, 4, 3);
    step();
    op_valid = 1'b0;
    check("same req_valid", req_valid, 2'b01);
    check("same first", ch_laddr(0), 40'h102);
    check("same first l2", req_l2[0], 1);
    step();
    check("same second", ch_laddr(0), 40'h104);
    check("same second l2", req_l2[0], 1);
    check("same ndrop", ndrop, 1);
    step();
    // duplicate merge
    set_op(39'h100, 3, 5, 3, 2);
    step();
    op_valid = 1'b0;
    check("dup req_valid", req_valid, 2'b10);
    check("dup laddr", ch_laddr(1), 40'h103);
    check("dup l2", req_l2[1], 0);
    check("dup ndrop", ndrop, 2);
    step();
    check("dup single", req_valid, 2'b00);
    // wrap and zero delta
    set_op('1, 1, 7, 0, 7);
    step();
    op_valid = 1'b0;
    check("wrap req_valid", req_valid, 2'b01);
    check("wrap laddr", ch_laddr(0), 40'h0);
    check("wrap l2", req_l2[0], 0);
    check("wrap ndrop", ndrop, 3);
    // stats saturation
    for (int p = 0; p < NPIPE; p++)
      for (int k = 0; k < 8; k++)
        stats_in[(p*8+k)*STATBITS +: STATBITS] = k == 0 ? 16'h8000 : 16'(p * 'h1000 + k * 'h111);
    step();
    check("stats c0", stats_out[0 +: 16], 16'hFFFF);
    check("stats c1", stats_out[16 +: 16], 16'h1222);
    check("stats c7", stats_out[112 +: 16], 16'h1EEE);
    // back-pressure on channel 0 while channel 1 drains
    req_retry = 2'b01;
    for (int n = 0; n < 6; n++) begin
      set_op(39'h200 + 39'(n * 4), 2, 7, 3, 7);
      step();
      check($sformatf("bp op_retry %0d", n), op_retry, n >= 2);
      if (n < 3) check($sformatf("bp ch1 live %0d", n), req_valid[1], 1);
    end
    op_valid = 1'b0;
    check("bp ch0 held", ch_laddr(0), 40'h202);
    req_retry = 2'b00;
    for (int n = 0; n < 5; n++) step();
    check("bp drained", req_valid, 2'b00);
    // reset with FIFOs partly full
    req_retry = 2'b11;
    set_op(39'h300, 2, 7, 4, 7);
    step();
    op_laddr = 39'h308;
    step();
    check("rst pre retry", op_retry, 1);
    rst_n = 1'b0;
    step();
    check("rst req_valid", req_valid, 2'b00);
    check("rst ndrop", ndrop, 0);
    check("rst stats", stats_out, 0);
    check("rst op_retry", op_retry, 0);
    rst_n = 1'b1;
    op_valid = 1'b0;
    step();
    check("rst discard", req_valid, 2'b00);
    check("rst op_retry next", op_retry, 0);
    req_retry = 2'b00;
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int d, d2;
      d = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(0, 255));
      d2 = $urandom_range(0, 3) == 0 ? d : ($urandom_range(0, 4) == 0 ? 0 : int'($urandom_range(0, 255)));
      set_op(39'({$urandom, $urandom}), d, $urandom_range(0, 7), d2, $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) op_laddr = '1 - 39'($urandom_range(0, 3));
      op_valid = $urandom_range(0, 3) != 0;
      req_retry = NPIPE'($urandom_range(0, 3) == 0 ? 3 : $urandom_range(0, 3) & $urandom_range(0, 3));
      for (int j = 0; j < NPIPE * 8; j++)
        stats_in[j*STATBITS +: STATBITS] = $urandom_range(0, 1) ? 16'h8000 + 16'($urandom_range(0, 255)) : 16'($urandom);
      rst_n = $urandom_range(0, 399) != 0;
      step();
    end
    rst_n = 1'b1;
    op_valid = 1'b0;
    req_retry = '0;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
